// File: rtl/alu_exec_q.sv
// RV32I integer execute unit with an epoch-aware, in-order result queue.
// One uop is computed per accepted request; dead (wrong-path) results drain without writeback.
package alu_exec_q_pkg;
    localparam int EPOCH_W = 2;
    localparam int ROB_W   = 6;
    localparam int PHYS_W  = 7;

    localparam logic [1:0] SRC_RS1  = 2'd0;
    localparam logic [1:0] SRC_PC   = 2'd1;
    localparam logic [1:0] SRC_ZERO = 2'd2;
    localparam logic [1:0] SRC_RS2  = 2'd0;
    localparam logic [1:0] SRC_IMM  = 2'd1;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_SLL   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_SLT   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;
    localparam logic [4:0] OP_ADDI  = 5'd10;
    localparam logic [4:0] OP_ANDI  = 5'd11;
    localparam logic [4:0] OP_ORI   = 5'd12;
    localparam logic [4:0] OP_XORI  = 5'd13;
    localparam logic [4:0] OP_SLLI  = 5'd14;
    localparam logic [4:0] OP_SRLI  = 5'd15;
    localparam logic [4:0] OP_SRAI  = 5'd16;
    localparam logic [4:0] OP_SLTI  = 5'd17;
    localparam logic [4:0] OP_SLTIU = 5'd18;
    localparam logic [4:0] OP_LUI   = 5'd19;
    localparam logic [4:0] OP_AUIPC = 5'd20;

    typedef struct packed {
        logic [4:0]         op;
        logic [1:0]         src1_select;
        logic [1:0]         src2_select;
        logic [31:0]        imm;
        logic [31:0]        pc;
        logic               uses_rd;
        logic [ROB_W-1:0]   rob_idx;
        logic [PHYS_W-1:0]  prd_new;
        logic [EPOCH_W-1:0] epoch;
    } rs_uop_t;
endpackage

module alu_exec_q
    import alu_exec_q_pkg::*;
#(
    parameter int                 DEPTH       = 4,
    parameter logic [EPOCH_W-1:0] RESET_EPOCH = '0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  rs_uop_t                    i_req_uop,
    input  logic [31:0]                i_rs1_val,
    input  logic [31:0]                i_rs2_val,
    input  logic                       i_flush_valid,
    input  logic [EPOCH_W-1:0]         i_flush_epoch,
    output logic                       o_wb_valid,
    input  logic                       i_wb_ready,
    output logic [31:0]                o_wb_pc,
    output logic                       o_wb_uses_rd,
    output logic [ROB_W-1:0]           o_wb_rob_idx,
    output logic [PHYS_W-1:0]          o_wb_prd_new,
    output logic [EPOCH_W-1:0]         o_wb_epoch,
    output logic [31:0]                o_wb_data,
    output logic [$clog2(DEPTH):0]     o_occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic [CW-1:0]      r_count;
    logic [EPOCH_W-1:0] r_cur_epoch;
    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   r_dead;

    logic [31:0]        r_data    [DEPTH];
    logic [31:0]        r_pc      [DEPTH];
    logic               r_uses_rd [DEPTH];
    logic [ROB_W-1:0]   r_rob     [DEPTH];
    logic [PHYS_W-1:0]  r_prd     [DEPTH];
    logic [EPOCH_W-1:0] r_epoch   [DEPTH];

    logic [31:0]        w_op_a;
    logic [31:0]        w_op_b;
    logic [31:0]        w_result;
    logic [4:0]         w_sh;
    logic [4:0]         w_shi;
    logic               w_head_live;
    logic               w_pop;
    logic               w_push;
    logic [EPOCH_W-1:0] w_eff_epoch;

    always_comb begin
        w_op_a = '0;
        case (i_req_uop.src1_select)
            SRC_RS1: w_op_a = i_rs1_val;
            SRC_PC:  w_op_a = i_req_uop.pc;
            default: w_op_a = '0;
        endcase
        w_op_b = '0;
        case (i_req_uop.src2_select)
            SRC_RS2: w_op_b = i_rs2_val;
            SRC_IMM: w_op_b = i_req_uop.imm;
            default: w_op_b = '0;
        endcase
    end

    assign w_sh  = w_op_b[4:0];
    assign w_shi = i_req_uop.imm[4:0];

    always_comb begin
        w_result = '0;
        case (i_req_uop.op)
            OP_ADD, OP_ADDI, OP_AUIPC: w_result = w_op_a + w_op_b;
            OP_SUB:                    w_result = w_op_a - w_op_b;
            OP_AND, OP_ANDI:           w_result = w_op_a & w_op_b;
            OP_OR, OP_ORI:             w_result = w_op_a | w_op_b;
            OP_XOR, OP_XORI:           w_result = w_op_a ^ w_op_b;
            OP_SLL:                    w_result = w_op_a << w_sh;
            OP_SRL:                    w_result = w_op_a >> w_sh;
            OP_SRA:                    w_result = 32'($signed(w_op_a) >>> w_sh);
            OP_SLLI:                   w_result = w_op_a << w_shi;
            OP_SRLI:                   w_result = w_op_a >> w_shi;
            OP_SRAI:                   w_result = 32'($signed(w_op_a) >>> w_shi);
            OP_SLT, OP_SLTI:           w_result = {31'd0, $signed(w_op_a) < $signed(w_op_b)};
            OP_SLTU, OP_SLTIU:         w_result = {31'd0, w_op_a < w_op_b};
            OP_LUI:                    w_result = w_op_b;
            default:                   w_result = '0;
        endcase
    end

    // A dead head leaves without waiting for the writeback side.
    assign w_head_live = r_valid[r_head] && !r_dead[r_head];
    assign w_pop       = r_valid[r_head] && (r_dead[r_head] || i_wb_ready);
    assign o_req_ready = (r_count < DEPTH_C) || w_pop;
    assign w_push      = i_req_valid && o_req_ready;
    assign w_eff_epoch = i_flush_valid ? i_flush_epoch : r_cur_epoch;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_valid     <= '0;
            r_dead      <= '0;
            r_cur_epoch <= RESET_EPOCH;
        end else begin
            if (i_flush_valid) r_cur_epoch <= i_flush_epoch;
            if (w_pop)  r_head <= r_head + 1'b1;
            if (w_push) r_tail <= r_tail + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Later assignments win: a push into the slot being popped (full queue) takes priority.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_pop && r_head == PW'(i)) r_valid[i] <= 1'b0;
                if (i_flush_valid && r_valid[i] && r_epoch[i] != i_flush_epoch) r_dead[i] <= 1'b1;
                if (w_push && r_tail == PW'(i)) begin
                    r_valid[i] <= 1'b1;
                    r_dead[i]  <= (i_req_uop.epoch != w_eff_epoch);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_data[r_tail]    <= w_result;
            r_pc[r_tail]      <= i_req_uop.pc;
            r_uses_rd[r_tail] <= i_req_uop.uses_rd;
            r_rob[r_tail]     <= i_req_uop.rob_idx;
            r_prd[r_tail]     <= i_req_uop.prd_new;
            r_epoch[r_tail]   <= i_req_uop.epoch;
        end
    end

    // Payload reads as zero whenever nothing live is presented.
    assign o_wb_valid   = w_head_live;
    assign o_wb_data    = w_head_live ? r_data[r_head]    : '0;
    assign o_wb_pc      = w_head_live ? r_pc[r_head]      : '0;
    assign o_wb_uses_rd = w_head_live ? r_uses_rd[r_head] : 1'b0;
    assign o_wb_rob_idx = w_head_live ? r_rob[r_head]     : '0;
    assign o_wb_prd_new = w_head_live ? r_prd[r_head]     : '0;
    assign o_wb_epoch   = w_head_live ? r_epoch[r_head]   : '0;
    assign o_occupancy  = r_count;
endmodule

// File: doc/alu_exec_q.md
# alu_exec_q

Parametrised RV32I integer execute unit. It computes one ALU uop per accepted request and buffers results in a DEPTH-entry in-order result queue feeding the writeback/ROB-complete port. It is epoch-aware: a flush marks queued wrong-path results dead, and dead results drain without a writeback. It sits between the ALU reservation-station issue port and the CDB/ROB writeback arbiter.

## Interface
- DEPTH, 4, result-queue entries; power of two, 2..16.
- RESET_EPOCH, 0, value of the current-epoch register after reset.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- req_valid  in  1  issue request valid.
- req_ready  out  1  unit can accept a request this cycle.
- req_uop  in  rs_uop_t  issued uop: bundle (op, src1_select, src2_select, imm, pc, uses_rd), rob_idx, prd_new, epoch.
- rs1_val, rs2_val  in  32 each  source operand values.
- flush_valid  in  1  epoch change (branch mispredict recovery).
- flush_epoch  in  EPOCH_W  new current epoch.
- wb_valid  out  1  head result is live and presented.
- wb_ready  in  1  writeback accepts the result.
- wb_pc  out  32  PC of the head uop.
- wb_uses_rd  out  1  head uop writes rd.
- wb_rob_idx  out  ROB_W  ROB index of the head uop.
- wb_prd_new  out  PHYS_W  destination physical register.
- wb_epoch  out  EPOCH_W  epoch of the head uop.
- wb_data  out  32  result.
- occupancy  out  $clog2(DEPTH)+1  queued entries, live and dead.

## Operation
- Operand mux: op_a = rs1_val / pc / 0 for SRC_RS1 / SRC_PC / SRC_ZERO. op_b = rs2_val / imm for SRC_RS2 / SRC_IMM. Any other select gives 0.
- Ops:
  - ADD/ADDI/AUIPC: a+b. SUB: a-b. AND/OR/XOR and their immediate forms: bitwise.
  - SLLI/SRLI/SRAI: shift by imm[4:0]. SLL/SRL/SRA: shift by op_b[4:0]. SRA variants are arithmetic.
  - SLT/SLTI: signed compare. SLTU/SLTIU: unsigned compare. Each gives 32'd1 or 32'd0.
  - LUI: op_b. Unknown op: 0.
  - All arithmetic is mod 2^32; no overflow flags.
- Queue: circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register. Each entry holds the payload, a valid bit and a dead bit.
- Enqueue fire: req_valid && req_ready. The entry is written at tail, valid=1. dead=1 if req_uop.epoch != effective epoch, where effective epoch = flush_epoch when flush_valid, else cur_epoch. Wrong-path requests are still accepted.
- Flush: cur_epoch <= flush_epoch. Every valid entry whose epoch != flush_epoch gets dead=1 at the next edge. Entries whose epoch matches are untouched.
- Dequeue:
  - Live head: wb_valid=1; pops when wb_ready=1.
  - Dead head: wb_valid=0; pops unconditionally, one per cycle.
- req_ready = (count < DEPTH) || head pops this cycle.
- occupancy = count; it includes dead entries.

## Timing
- Compute latency: 1 cycle. A request accepted at edge N is presented on wb_* in cycle N+1 if the queue was empty (wb_valid=1 then).
- Throughput: 1 request/cycle and 1 writeback/cycle sustained.
- Simultaneous enqueue and pop: count unchanged, both pointers advance. When full, an enqueue is allowed only in a cycle where the head pops.
- Flush in the same cycle as a live-head handshake: that handshake completes and the result is written back. Flushes affect only state after the edge.
- Flush in the same cycle as an enqueue: the new entry is judged against flush_epoch.
- Back-to-back flushes: each uses its own flush_epoch. An entry once dead stays dead.
- Reset:
  - Output values: req_ready=1, wb_valid=0, all wb_* payload=0, occupancy=0.
  - Internal state: cur_epoch=RESET_EPOCH; pointers, count and all valid/dead bits cleared.
  - Reset mid-operation discards all queued entries and ignores the flush and req inputs in that cycle.
- wb_* payload is stable while wb_valid=1 and wb_ready=0.

## Test plan
- Basic ops, wb_ready=1:
  - ADDI rs1=5, imm=-3 -> wb_data=2, one cycle after accept.
  - SRA rs1=0x80000000, rs2=4 -> 0xF8000000.
  - SLTU 1 vs 0xFFFFFFFF -> 1.
  - AUIPC pc=0x1000, imm=0x2000 -> 0x3000.
- Backpressure, DEPTH=4, wb_ready=0, 6 requests offered:
  - 4 accepted, occupancy=4, req_ready=0.
  - Then raise wb_ready: results come out in order with rob_idx 0..3; pointers wrap correctly on the next 2 requests.
- Full plus simultaneous pop: queue full, wb_ready=1 and req_valid=1 -> req_ready=1, occupancy stays 4, no entry lost or duplicated.
- Flush kill: queue holds epochs {0,0,1,1} at cur_epoch=1; flush to epoch 1 -> the two epoch-0 entries drain with wb_valid=0 in 2 cycles, then the epoch-1 results write back.
- Flush with enqueue in the same cycle: flush_epoch=2 while a request with epoch=1 is accepted -> the entry is dead and never asserts wb_valid. A request with epoch=2 writes back.
- Reset mid-stream with 3 entries queued: after rst, wb_valid=0, occupancy=0, req_ready=1, and the next ADD 7+8 -> 15 with no stale output.
